// File: rtl/mult_booth_n.sv
// Sequential radix-2 Booth multiplier, N-bit operands, 2N-bit product.
// Signed or unsigned per request, with a start/done handshake.
module mult_booth_n #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           tc,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int W  = N + 1;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state, state_n;

  logic [W:0]    a;
  logic [W-1:0]  m;
  logic [W-1:0]  q;
  logic          qm1;
  logic [CW-1:0] count;

  logic [W:0]   m_x;
  logic [W:0]   sum;
  logic [W:0]   a_n;
  logic [W-1:0] q_n;
  logic         last;

  // Guard bit on A keeps A +/- M exact before the shift.
  always_comb begin
    m_x = {m[W-1], m};
    sum = a;
    unique case ({q[0], qm1})
      2'b01:   sum = a + m_x;
      2'b10:   sum = a + ~m_x + (W+1)'(1);
      default: sum = a;
    endcase
    a_n  = {sum[W], sum[W:1]};
    q_n  = {sum[0], q[W-1:1]};
    last = (count == CW'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_n = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_n = FIN;
      end
      FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a       <= '0;
      m       <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            m     <= {tc & multiplicand[N-1], multiplicand};
            q     <= {tc & multiplier[N-1], multiplier};
            a     <= '0;
            qm1   <= 1'b0;
            count <= CW'(W);
          end
        end
        CALC: begin
          a     <= a_n;
          q     <= q_n;
          qm1   <= q[0];
          count <= count - CW'(1);
          if (last) product <= {a_n[N-2:0], q_n};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth_n.sv
// Scoreboard bench for mult_booth_n: N=4 and N=8 instances,
// random and directed multiplies checked against plain integer arithmetic.
module tb_mult_booth_n;

  localparam int N4 = 4;
  localparam int N8 = 8;

  typedef struct {
    longint prod;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic         start4 = 1'b0, tc4 = 1'b0;
  logic [3:0]   m4 = '0, q4 = '0;
  logic         ready4, busy4, done4;
  logic [7:0]   product4;

  logic         start8 = 1'b0, tc8 = 1'b0;
  logic [7:0]   m8 = '0, q8 = '0;
  logic         ready8, busy8, done8;
  logic [15:0]  product8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fa4 = 0, fa8 = 0;
  longint last4 = 0, last8 = 0;
  exp_t sb4[$];
  exp_t sb8[$];

  mult_booth_n #(.N(N4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .tc(tc4),
    .multiplicand(m4), .multiplier(q4),
    .ready(ready4), .busy(busy4), .done(done4), .product(product4)
  );

  mult_booth_n #(.N(N8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .tc(tc8),
    .multiplicand(m8), .multiplier(q8),
    .ready(ready8), .busy(busy8), .done(done8), .product(product8)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic longint ref_mul(int n, bit t, longint mv, longint qv);
    longint a, b, p;
    a = mv;
    b = qv;
    if (t && a[n-1]) a = a - (longint'(1) << n);
    if (t && b[n-1]) b = b - (longint'(1) << n);
    p = a * b;
    return p & ((longint'(1) << (2 * n)) - 1);
  endfunction

  // Acceptance model: one request per N+3 cycles while idle.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!reset && start4 && cyc >= fa4) begin
      e.prod = ref_mul(N4, tc4, longint'(m4), longint'(q4));
      e.cyc  = cyc + N4 + 1;
      sb4.push_back(e);
      fa4 = cyc + N4 + 3;
    end
    if (!reset && start8 && cyc >= fa8) begin
      e.prod = ref_mul(N8, tc8, longint'(m8), longint'(q8));
      e.cyc  = cyc + N8 + 1;
      sb8.push_back(e);
      fa8 = cyc + N8 + 3;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("ready4", longint'(ready4), longint'(cyc + 1 >= fa4));
    chk("busy4", longint'(busy4), longint'(cyc + 1 < fa4));
    if (done4) begin
      if (sb4.size() == 0) begin
        chk("extra_done4", longint'(done4), 0);
      end else begin
        e = sb4.pop_front();
        chk("prod4", longint'(product4), e.prod);
        chk("lat4", longint'(cyc), longint'(e.cyc));
        last4 = e.prod;
      end
    end else begin
      if (sb4.size() > 0 && cyc >= sb4[0].cyc) begin
        chk("missing_done4", longint'(done4), 1);
        void'(sb4.pop_front());
      end
      chk("hold4", longint'(product4), last4);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    chk("ready8", longint'(ready8), longint'(cyc + 1 >= fa8));
    chk("busy8", longint'(busy8), longint'(cyc + 1 < fa8));
    if (done8) begin
      if (sb8.size() == 0) begin
        chk("extra_done8", longint'(done8), 0);
      end else begin
        e = sb8.pop_front();
        chk("prod8", longint'(product8), e.prod);
        chk("lat8", longint'(cyc), longint'(e.cyc));
        last8 = e.prod;
      end
    end else begin
      if (sb8.size() > 0 && cyc >= sb8[0].cyc) begin
        chk("missing_done8", longint'(done8), 1);
        void'(sb8.pop_front());
      end
      chk("hold8", longint'(product8), last8);
    end
  end

  task automatic issue4(bit t, logic [3:0] mv, logic [3:0] qv);
    @(negedge clk);
    tc4 = t; m4 = mv; q4 = qv; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    m4 = 4'($urandom); q4 = 4'($urandom); tc4 = 1'($urandom);
    repeat (N4 + 2) @(negedge clk);
  endtask

  task automatic issue8(bit t, logic [7:0] mv, logic [7:0] qv);
    @(negedge clk);
    tc8 = t; m8 = mv; q8 = qv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    m8 = 8'($urandom); q8 = 8'($urandom); tc8 = 1'($urandom);
    repeat (N8 + 2) @(negedge clk);
  endtask

  initial begin
    #3;
    chk("rst_prod4", longint'(product4), 0);
    chk("rst_ready4", longint'(ready4), 1);
    chk("rst_busy4", longint'(busy4), 0);
    chk("rst_done4", longint'(done4), 0);
    @(posedge clk);
    #2 reset = 1'b0;

    issue4(1'b1, 4'd3, 4'hE);
    issue4(1'b1, 4'h8, 4'h8);
    issue4(1'b0, 4'hF, 4'hF);
    issue4(1'b0, 4'h8, 4'h8);
    issue4(1'b0, 4'h0, 4'h9);
    issue4(1'b1, 4'h7, 4'hF);
    for (int i = 0; i < 30; i++)
      issue4(1'($urandom), 4'($urandom), 4'($urandom));

    // Start held high with operands churning every cycle.
    @(negedge clk);
    start4 = 1'b1;
    repeat (3 * (N4 + 3)) begin
      @(negedge clk);
      m4 = 4'($urandom); q4 = 4'($urandom); tc4 = 1'($urandom);
    end
    start4 = 1'b0;
    repeat (N4 + 4) @(negedge clk);

    // Stray start pulses in CALC and in DONE.
    @(negedge clk);
    tc4 = 1'b1; m4 = 4'h5; q4 = 4'hB; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; m4 = 4'h2; q4 = 4'h3;
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    start4 = 1'b1; m4 = 4'h6;
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset at CALC step 2.
    @(negedge clk);
    tc4 = 1'b1; m4 = 4'h6; q4 = 4'h5; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    sb4.delete(); sb8.delete();
    fa4 = 0; fa8 = 0; last4 = 0; last8 = 0;
    #1;
    chk("arst_prod4", longint'(product4), 0);
    chk("arst_done4", longint'(done4), 0);
    chk("arst_busy4", longint'(busy4), 0);
    chk("arst_ready4", longint'(ready4), 1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (N4 + 3) @(negedge clk);
    issue4(1'b1, 4'h6, 4'hD);

    issue8(1'b1, 8'h80, 8'h7F);
    issue8(1'b0, 8'hFF, 8'hFF);
    issue8(1'b1, 8'h80, 8'h80);
    for (int i = 0; i < 15; i++)
      issue8(1'($urandom), 8'($urandom), 8'($urandom));

    repeat (4) @(negedge clk);
    chk("drain4", longint'(sb4.size()), 0);
    chk("drain8", longint'(sb8.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
